// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy bit and ROB tag.
// Looks up operands (with commit bypass), renames rd, and registers the result toward the ROB.
module rename_reg_file #(
   parameter  int NREG  = 32,
   parameter  int XLEN  = 32,
   parameter  int TAG_W = 4,
   parameter  int PAY_W = 80,
   localparam int RB    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_valid_i,
   output logic             iss_ready_o,
   input  logic [RB-1:0]    iss_rs1_i,
   input  logic [RB-1:0]    iss_rs2_i,
   input  logic [RB-1:0]    iss_rd_i,
   input  logic             iss_wr_i,
   input  logic [TAG_W-1:0] iss_tag_i,
   input  logic [PAY_W-1:0] iss_pay_i,
   input  logic             cm_valid_i,
   input  logic [RB-1:0]    cm_rd_i,
   input  logic [TAG_W-1:0] cm_tag_i,
   input  logic [XLEN-1:0]  cm_val_i,
   input  logic             fl_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  out_vj_o,
   output logic [XLEN-1:0]  out_vk_o,
   output logic             out_bj_o,
   output logic             out_bk_o,
   output logic [TAG_W-1:0] out_qj_o,
   output logic [TAG_W-1:0] out_qk_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic [PAY_W-1:0] out_pay_o
);

   logic [XLEN-1:0]  val_q [NREG];
   logic [NREG-1:0]  busy_q;
   logic [TAG_W-1:0] tag_q [NREG];

   logic             accept, rename, wake_j, wake_k;
   logic [XLEN-1:0]  vj, vk;
   logic             bj, bk;
   logic [TAG_W-1:0] qj, qk;

   // Returns {busy, tag, value}; x0 is hard-wired to zero and never pending.
   function automatic logic [XLEN+TAG_W:0] lookup(
      input logic [RB-1:0]    rs,
      input logic [XLEN-1:0]  v,
      input logic             b,
      input logic [TAG_W-1:0] t,
      input logic             cv,
      input logic [RB-1:0]    crd,
      input logic [TAG_W-1:0] ctag,
      input logic [XLEN-1:0]  cval
   );
      if (rs == '0) return {1'b0, t, {XLEN{1'b0}}};
      if (b && cv && (crd == rs) && (ctag == t)) return {1'b0, t, cval};
      return {b, t, v};
   endfunction

   assign {bj, qj, vj} = lookup(iss_rs1_i, val_q[iss_rs1_i], busy_q[iss_rs1_i], tag_q[iss_rs1_i],
                                cm_valid_i, cm_rd_i, cm_tag_i, cm_val_i);
   assign {bk, qk, vk} = lookup(iss_rs2_i, val_q[iss_rs2_i], busy_q[iss_rs2_i], tag_q[iss_rs2_i],
                                cm_valid_i, cm_rd_i, cm_tag_i, cm_val_i);

   assign iss_ready_o = !out_valid_o || out_ready_i;
   assign accept      = iss_valid_i && iss_ready_o && !fl_i;
   assign rename      = accept && iss_wr_i && (iss_rd_i != '0);
   assign wake_j      = out_bj_o && cm_valid_i && (cm_tag_i == out_qj_o);
   assign wake_k      = out_bk_o && cm_valid_i && (cm_tag_i == out_qk_o);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         if (cm_valid_i && (cm_rd_i != '0)) val_q[cm_rd_i] <= cm_val_i;
         if (fl_i) begin
            busy_q <= '0;
         end else begin
            // A same-cycle rename of the committed register keeps it busy under the new tag.
            if (cm_valid_i && (cm_rd_i != '0) && (tag_q[cm_rd_i] == cm_tag_i)
                && !(rename && (iss_rd_i == cm_rd_i)))
               busy_q[cm_rd_i] <= 1'b0;
            if (rename) busy_q[iss_rd_i] <= 1'b1;
         end
         if (rename) tag_q[iss_rd_i] <= iss_tag_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o <= 1'b0;
         out_vj_o    <= '0;
         out_vk_o    <= '0;
         out_bj_o    <= 1'b0;
         out_bk_o    <= 1'b0;
         out_qj_o    <= '0;
         out_qk_o    <= '0;
         out_tag_o   <= '0;
         out_pay_o   <= '0;
      end else if (fl_i) begin
         out_valid_o <= 1'b0;
      end else if (accept) begin
         out_valid_o <= 1'b1;
         out_vj_o    <= vj;
         out_vk_o    <= vk;
         out_bj_o    <= bj;
         out_bk_o    <= bk;
         out_qj_o    <= qj;
         out_qk_o    <= qk;
         out_tag_o   <= iss_tag_i;
         out_pay_o   <= iss_pay_i;
      end else if (out_valid_o && out_ready_i) begin
         out_valid_o <= 1'b0;
      end else if (out_valid_o) begin
         // Operands of a stalled entry pick up their producer's commit in place.
         if (wake_j) begin
            out_vj_o <= cm_val_i;
            out_bj_o <= 1'b0;
         end
         if (wake_k) begin
            out_vk_o <= cm_val_i;
            out_bk_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed scenarios with constant expectations, then random
// traffic checked against an array-based reference model.
module tb_rename_reg_file;
   localparam int NREG = 32, XLEN = 32, TAG_W = 4, PAY_W = 80, RB = 5;

   logic clk = 1'b0;
   logic rst;
   logic iss_valid, iss_ready, iss_wr, cm_valid, fl, out_valid, out_ready;
   logic [RB-1:0] iss_rs1, iss_rs2, iss_rd, cm_rd;
   logic [TAG_W-1:0] iss_tag, cm_tag, out_qj, out_qk, out_tag;
   logic [PAY_W-1:0] iss_pay, out_pay;
   logic [XLEN-1:0] cm_val, out_vj, out_vk;
   logic out_bj, out_bk;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [XLEN-1:0]  m_val [NREG];
   bit               m_busy [NREG];
   logic [TAG_W-1:0] m_tag [NREG];
   bit               m_ov, m_bj, m_bk;
   logic [XLEN-1:0]  m_vj, m_vk;
   logic [TAG_W-1:0] m_qj, m_qk, m_otag;
   logic [PAY_W-1:0] m_opay;

   rename_reg_file #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .PAY_W(PAY_W)) dut (
      .clk(clk), .rst(rst),
      .iss_valid_i(iss_valid), .iss_ready_o(iss_ready),
      .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .iss_rd_i(iss_rd),
      .iss_wr_i(iss_wr), .iss_tag_i(iss_tag), .iss_pay_i(iss_pay),
      .cm_valid_i(cm_valid), .cm_rd_i(cm_rd), .cm_tag_i(cm_tag), .cm_val_i(cm_val),
      .fl_i(fl),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_vj_o(out_vj), .out_vk_o(out_vk), .out_bj_o(out_bj), .out_bk_o(out_bk),
      .out_qj_o(out_qj), .out_qk_o(out_qk), .out_tag_o(out_tag), .out_pay_o(out_pay)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
      m_ov = 0; m_bj = 0; m_bk = 0; m_vj = '0; m_vk = '0;
      m_qj = '0; m_qk = '0; m_otag = '0; m_opay = '0;
   endtask

   // What a reader of register rs would see right now.
   task automatic model_read(input logic [RB-1:0] rs, output logic [XLEN-1:0] v,
                             output bit b, output logic [TAG_W-1:0] q);
      q = m_tag[rs];
      if (rs == 0) begin
         v = '0; b = 0;
      end else if (m_busy[rs] && cm_valid && cm_rd == rs && cm_tag == m_tag[rs]) begin
         v = cm_val; b = 0;
      end else begin
         v = m_val[rs]; b = m_busy[rs];
      end
   endtask

   // One clock: sample inputs, advance the model, return at posedge+1.
   task automatic cyc();
      bit acc, ren, bj, bk, cm_clear;
      logic [XLEN-1:0] vj, vk;
      logic [TAG_W-1:0] qj, qk;
      acc = iss_valid && (!m_ov || out_ready) && !fl;
      ren = acc && iss_wr && iss_rd != 0;
      model_read(iss_rs1, vj, bj, qj);
      model_read(iss_rs2, vk, bk, qk);
      cm_clear = cm_valid && cm_rd != 0 && m_tag[cm_rd] == cm_tag && !(ren && iss_rd == cm_rd);
      @(posedge clk); #1;
      if (fl) m_ov = 0;
      else if (acc) begin
         m_ov = 1; m_vj = vj; m_vk = vk; m_bj = bj; m_bk = bk;
         m_qj = qj; m_qk = qk; m_otag = iss_tag; m_opay = iss_pay;
      end else if (m_ov && out_ready) m_ov = 0;
      else if (m_ov) begin
         if (m_bj && cm_valid && cm_tag == m_qj) begin m_vj = cm_val; m_bj = 0; end
         if (m_bk && cm_valid && cm_tag == m_qk) begin m_vk = cm_val; m_bk = 0; end
      end
      if (cm_valid && cm_rd != 0) m_val[cm_rd] = cm_val;
      if (fl) for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      else begin
         if (cm_clear) m_busy[cm_rd] = 0;
         if (ren) begin m_busy[iss_rd] = 1; m_tag[iss_rd] = iss_tag; end
      end
   endtask

   task automatic set_idle();
      iss_valid = 0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_wr = 0;
      iss_tag = '0; iss_pay = '0; cm_valid = 0; cm_rd = '0; cm_tag = '0;
      cm_val = '0; fl = 0; out_ready = 1;
   endtask

   task automatic issue(input int rs1, input int rs2, input int rd, input bit wr, input int tag);
      iss_valid = 1; iss_rs1 = RB'(rs1); iss_rs2 = RB'(rs2); iss_rd = RB'(rd);
      iss_wr = wr; iss_tag = TAG_W'(tag);
      iss_pay = PAY_W'({$urandom, $urandom, $urandom});
   endtask

   task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] v);
      cm_valid = 1; cm_rd = RB'(rd); cm_tag = TAG_W'(tag); cm_val = v;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 0;
      model_reset();
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", iss_ready); end
      checks++; if ({out_vj, out_vk, out_bj, out_bk, out_qj, out_qk, out_tag} !== '0)
         begin errors++; $display("FAIL reset_data got %h exp 0", {out_vj, out_vk, out_bj, out_bk, out_qj, out_qk, out_tag}); end
      checks++; if (out_pay !== '0) begin errors++; $display("FAIL reset_pay got %h exp 0", out_pay); end
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_issue_bypass();
      logic [PAY_W-1:0] pay;
      issue(1, 2, 3, 1, 5); pay = iss_pay; cyc();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL iss_valid got %0b exp 1", out_valid); end
      checks++; if ({out_bj, out_bk} !== 2'b00) begin errors++; $display("FAIL iss_busy got %b exp 00", {out_bj, out_bk}); end
      checks++; if ({out_vj, out_vk} !== '0) begin errors++; $display("FAIL iss_vals got %h exp 0", {out_vj, out_vk}); end
      checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL iss_tag got %0d exp 5", out_tag); end
      checks++; if (out_pay !== pay) begin errors++; $display("FAIL iss_pay got %h exp %h", out_pay, pay); end
      issue(3, 0, 0, 0, 1); cyc();
      checks++; if (out_bj !== 1'b1 || out_qj !== 4'd5)
         begin errors++; $display("FAIL busy3 got bj=%0b qj=%0d exp bj=1 qj=5", out_bj, out_qj); end
      issue(3, 3, 0, 0, 2); commit(3, 5, 32'hDEAD); cyc();
      cm_valid = 0;
      checks++; if (out_bj !== 1'b0 || out_vj !== 32'hDEAD)
         begin errors++; $display("FAIL bypass got bj=%0b vj=%h exp bj=0 vj=dead", out_bj, out_vj); end
      issue(3, 0, 0, 0, 3); cyc();
      checks++; if (out_bj !== 1'b0 || out_vj !== 32'hDEAD)
         begin errors++; $display("FAIL commit3 got bj=%0b vj=%h exp bj=0 vj=dead", out_bj, out_vj); end
   endtask

   task automatic test_back_to_back();
      issue(0, 0, 12, 1, 4); cyc();
      issue(12, 12, 13, 1, 8); cyc();
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'd8)
         begin errors++; $display("FAIL b2b_out got v=%0b tag=%0d exp v=1 tag=8", out_valid, out_tag); end
      checks++; if ({out_bj, out_qj, out_bk, out_qk} !== {1'b1, 4'd4, 1'b1, 4'd4})
         begin errors++; $display("FAIL b2b_dep got bj=%0b qj=%0d bk=%0b qk=%0d exp 1/4/1/4", out_bj, out_qj, out_bk, out_qk); end
      issue(13, 0, 0, 0, 9); cyc();
      checks++; if (out_bj !== 1'b1 || out_qj !== 4'd8)
         begin errors++; $display("FAIL b2b_dep2 got bj=%0b qj=%0d exp bj=1 qj=8", out_bj, out_qj); end
   endtask

   task automatic test_rename_order();
      set_idle();
      issue(0, 0, 4, 1, 2); cyc();
      issue(0, 0, 4, 1, 7); cyc();
      set_idle(); commit(4, 2, 32'h11); cyc();
      set_idle(); issue(4, 0, 0, 0, 1); cyc();
      checks++; if (out_bj !== 1'b1 || out_qj !== 4'd7)
         begin errors++; $display("FAIL stale_commit got bj=%0b qj=%0d exp bj=1 qj=7", out_bj, out_qj); end
      set_idle(); fl = 1; cyc();
      set_idle(); issue(4, 0, 0, 0, 1); cyc();
      checks++; if (out_bj !== 1'b0 || out_vj !== 32'h11)
         begin errors++; $display("FAIL val4 got bj=%0b vj=%h exp bj=0 vj=11", out_bj, out_vj); end
      // rename and matching commit in the same cycle: the rename survives
      issue(0, 0, 4, 1, 3); cyc();
      issue(0, 0, 4, 1, 10); commit(4, 3, 32'h33); cyc();
      set_idle(); issue(4, 0, 0, 0, 1); cyc();
      checks++; if (out_bj !== 1'b1 || out_qj !== 4'd10)
         begin errors++; $display("FAIL rename_wins got bj=%0b qj=%0d exp bj=1 qj=10", out_bj, out_qj); end
   endtask

   task automatic test_stall_wakeup();
      set_idle();
      issue(0, 0, 5, 1, 6); cyc();
      issue(5, 0, 0, 0, 11); cyc();
      checks++; if (out_bj !== 1'b1 || out_qj !== 4'd6)
         begin errors++; $display("FAIL stall_pre got bj=%0b qj=%0d exp bj=1 qj=6", out_bj, out_qj); end
      out_ready = 0; issue(0, 0, 7, 1, 3); #1;
      checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b exp 0", iss_ready); end
      commit(5, 6, 32'h42); cyc();
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'd11)
         begin errors++; $display("FAIL stall_hold got v=%0b tag=%0d exp v=1 tag=11", out_valid, out_tag); end
      checks++; if (out_bj !== 1'b0 || out_vj !== 32'h42)
         begin errors++; $display("FAIL wakeup got bj=%0b vj=%h exp bj=0 vj=42", out_bj, out_vj); end
      checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL stall_ready2 got %0b exp 0", iss_ready); end
      cm_valid = 0; out_ready = 1; iss_valid = 0; cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got %0b exp 0", out_valid); end
      issue(7, 5, 0, 0, 12); cyc();
      checks++; if ({out_bj, out_bk} !== 2'b00 || out_vk !== 32'h42)
         begin errors++; $display("FAIL no_rename7 got bj=%0b bk=%0b vk=%h exp 0 0 42", out_bj, out_bk, out_vk); end
   endtask

   task automatic test_flush();
      set_idle();
      issue(0, 0, 1, 1, 1); cyc();
      issue(0, 0, 2, 1, 2); cyc();
      issue(0, 0, 3, 1, 3); cyc();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got %0b exp 1", out_valid); end
      fl = 1; out_ready = 0; issue(0, 0, 8, 1, 9); commit(10, 0, 32'h55); cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
      set_idle(); issue(1, 8, 0, 0, 4); cyc();
      checks++; if ({out_bj, out_bk} !== 2'b00 || out_vj !== 32'h0)
         begin errors++; $display("FAIL flush_busy18 got bj=%0b bk=%0b vj=%h exp 0 0 0", out_bj, out_bk, out_vj); end
      issue(2, 3, 0, 0, 5); cyc();
      checks++; if ({out_bj, out_bk} !== 2'b00)
         begin errors++; $display("FAIL flush_busy23 got %b exp 00", {out_bj, out_bk}); end
      issue(10, 0, 0, 0, 6); cyc();
      checks++; if (out_vj !== 32'h55) begin errors++; $display("FAIL flush_commit got %h exp 55", out_vj); end
   endtask

   task automatic test_x0();
      set_idle();
      issue(0, 0, 0, 1, 9); cyc();
      issue(0, 0, 0, 0, 1); cyc();
      checks++; if (out_bj !== 1'b0 || out_vj !== 32'h0)
         begin errors++; $display("FAIL x0_rename got bj=%0b vj=%h exp 0 0", out_bj, out_vj); end
      issue(0, 0, 0, 0, 2); commit(0, 9, 32'hFF); cyc();
      set_idle(); issue(0, 0, 0, 0, 3); cyc();
      checks++; if (out_bj !== 1'b0 || out_vj !== 32'h0 || out_vk !== 32'h0)
         begin errors++; $display("FAIL x0_write got bj=%0b vj=%h vk=%h exp 0 0 0", out_bj, out_vj, out_vk); end
   endtask

   task automatic test_random(input int n);
      for (int c = 0; c < n; c++) begin
         int r;
         iss_valid = ($urandom_range(3) != 0);
         iss_rs1 = RB'($urandom_range(7)); iss_rs2 = RB'($urandom_range(7));
         iss_rd = RB'($urandom_range(7)); iss_wr = ($urandom_range(3) != 0);
         iss_tag = TAG_W'($urandom); iss_pay = PAY_W'({$urandom, $urandom, $urandom});
         out_ready = ($urandom_range(2) != 0);
         fl = ($urandom_range(39) == 0);
         cm_valid = $urandom_range(1); cm_val = $urandom;
         r = $urandom_range(7); cm_rd = RB'(r);
         cm_tag = ($urandom_range(3) != 0) ? m_tag[r] : TAG_W'($urandom);
         if (m_ov && m_bj && $urandom_range(3) == 0) cm_tag = m_qj;
         #1;
         checks++; if (iss_ready !== (!m_ov || out_ready))
            begin errors++; $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, iss_ready, !m_ov || out_ready); end
         cyc();
         checks++; if (out_valid !== m_ov)
            begin errors++; $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, out_valid, m_ov); end
         if (m_ov) begin
            checks++; if (out_tag !== m_otag || out_pay !== m_opay)
               begin errors++; $display("FAIL rnd_tagpay c=%0d got %0d/%h exp %0d/%h", c, out_tag, out_pay, m_otag, m_opay); end
            checks++; if (out_bj !== m_bj || out_bk !== m_bk)
               begin errors++; $display("FAIL rnd_busy c=%0d got %0b%0b exp %0b%0b", c, out_bj, out_bk, m_bj, m_bk); end
            checks++; if (m_bj ? (out_qj !== m_qj) : (out_vj !== m_vj))
               begin errors++; $display("FAIL rnd_j c=%0d got q=%0d v=%h exp q=%0d v=%h", c, out_qj, out_vj, m_qj, m_vj); end
            checks++; if (m_bk ? (out_qk !== m_qk) : (out_vk !== m_vk))
               begin errors++; $display("FAIL rnd_k c=%0d got q=%0d v=%h exp q=%0d v=%h", c, out_qk, out_vk, m_qk, m_vk); end
         end
      end
   endtask

   task automatic test_reset_midstream();
      set_idle(); issue(0, 0, 6, 1, 1); cyc();
      #2; rst = 0; #1;
      model_reset();
      checks++; if (out_valid !== 1'b0 || iss_ready !== 1'b1 || out_tag !== '0)
         begin errors++; $display("FAIL midrst_out got v=%0b r=%0b tag=%0d exp 0 1 0", out_valid, iss_ready, out_tag); end
      set_idle();
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      issue(6, 3, 0, 0, 2); cyc();
      checks++; if ({out_bj, out_bk} !== 2'b00 || {out_vj, out_vk} !== '0)
         begin errors++; $display("FAIL midrst_state got bj=%0b bk=%0b v=%h exp empty", out_bj, out_bk, {out_vj, out_vk}); end
   endtask

   initial begin
      test_reset();
      test_issue_bypass();
      test_back_to_back();
      test_rename_order();
      test_stall_wakeup();
      test_flush();
      test_x0();
      test_random(2000);
      test_reset_midstream();
      test_random(500);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
